maxnet_ctrl: RTL and testbench
==============================

# maxnet_ctrl

Iteration controller that sits directly downstream of the four-lane `pu` stage and closes the MaxNet loop around it. It loads four initial activations, drives them into the PU `x` inputs, waits for the PU result, and feeds each result back as the next `x` vector. It stops when exactly one lane stays nonzero, all lanes die out, or an iteration limit is hit. It then reports the winning lane index with a one-cycle `done` pulse.

## Interface
Parameters:
- `W`, 5: activation width, two's complement; matches the PU datapath.
- `PU_LAT`, 1: PU latency in cycles from an `x` change to a valid `out`.
- `MAX_ITER`, 16: maximum PU evaluations per run; must be at least 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `in0`..`in3`  in  W  initial activations, sampled on the accepted `start` edge.
- `pu_out0`..`pu_out3`  in  W  PU lane outputs.
- `x0`..`x3`  out  W  registered activations driven to the PU `x` inputs.
- `busy`  out  1  high from the accepted `start` until `done`, inclusive of the `done` cycle.
- `done`  out  1  single-cycle completion pulse.
- `found`  out  1  a unique winner exists; held until the next accepted `start`.
- `winner`  out  2  winning lane index; 0 when `found`=0; held.
- `timeout`  out  1  run ended on `MAX_ITER`; held.
- `iter_cnt`  out  clog2(MAX_ITER+1)  number of PU evaluations used in the current or last run; held.

## Operation
FSM states: IDLE, WAIT, CHECK, DONE.
- **IDLE**
  - On `start`=1: x0..x3 <= in0..in3; clear `found`, `winner`, `timeout`, `iter_cnt`; load the wait counter with PU_LAT; go to WAIT.
- **WAIT**
  - Decrement the wait counter; go to CHECK when it reaches 0.
- **CHECK**
  - Form v_i from pu_out_i (see Configuration); iter_cnt <= iter_cnt+1.
  - Let n = number of nonzero v_i.
  - n==1: found <= 1; winner <= index of that lane; go to DONE.
  - n==0: found <= 0; winner <= 0; go to DONE.
  - n>=2 and iter_cnt+1==MAX_ITER: timeout <= 1; found <= 0; winner <= 0; go to DONE.
  - Otherwise: x_i <= v_i; reload the wait counter with PU_LAT; go to WAIT.
- **DONE**
  - `done`=1 for this cycle only; go to IDLE.

Rules:
- `x0`..`x3` change only on an accepted `start` or on a CHECK feedback.
- `start` in any state other than IDLE is ignored.
- A `start` in the same cycle as `done` is also ignored, because the FSM is in DONE, not IDLE.
- Precedence in CHECK: n==1 beats n==0, which beats timeout. A unique winner found on the final permitted iteration reports found=1, timeout=0.
- `rst` overrides everything: state IDLE; all outputs and x0..x3 = 0; wait counter = 0.
- A reset during a run abandons it; no `done` is produced.

## Timing
- Reset values: x0..x3=0, busy=0, done=0, found=0, winner=0, timeout=0, iter_cnt=0.
- `start` accepted at edge E: x updated at E; `busy` high from E.
- `pu_out` is sampled at edge E+PU_LAT+1.
- Each further iteration costs PU_LAT+1 cycles.
- `done` is high in the cycle after the deciding CHECK edge; `busy` falls at the edge after that.
- Run of k evaluations: `done` is high during cycle E+k·(PU_LAT+1)+1. For example, PU_LAT=1 and k=3 give `done` at E+7.
- Earliest accepted restart: one edge after `done`.

## Configuration
Macro: `MAXNET_CLAMP_EN`.
- **Defined:** v_i = 0 when pu_out_i[W-1]=1, otherwise v_i = pu_out_i. Negative lanes are treated as dead, both for the count n and for feedback.
- **Not defined:** v_i = pu_out_i unmodified. Any nonzero bit pattern, including negatives, counts as alive and is fed back as-is.

## Test plan
The bench scripts `pu_out` directly. Unless stated, PU_LAT=1 and MAX_ITER=16.
1. **Convergence:** in=4,6,2,1; start; pu_out = 3,5,1,0 then 1,4,0,0 then 0,3,0,0 at the successive CHECKs -> x follows 4,6,2,1 -> 3,5,1,0 -> 1,4,0,0; done at E+7; found=1, winner=1, iter_cnt=3, timeout=0.
2. **All die:** in=2,2,2,2; pu_out=0,0,0,0 at the first CHECK -> done at E+3; found=0, winner=0, iter_cnt=1.
3. **Timeout:** MAX_ITER=8; pu_out held at 1,1,0,0 -> done at E+17; timeout=1, found=0, iter_cnt=8.
4. **Reset mid-run:** assert rst for one cycle during the second WAIT -> next cycle all outputs and x = 0, no `done`. A following start with in=0,5,0,0 and pu_out=0,5,0,0 -> found=1, winner=1.
5. **Clamp:** pu_out=5'b11111,2,0,0 at the first CHECK:
   - with `MAXNET_CLAMP_EN`: found=1, winner=1, iter_cnt=1;
   - without it: n=2, x <= 31,2,0,0 and the run continues.
6. **Start while busy:** pulse start with in=7,7,7,7 during WAIT -> ignored; x and iter_cnt are unaffected, and the run completes as in scenario 1.

Source files
------------

// File: rtl/maxnet_ctrl.sv
// maxnet_ctrl: iteration controller closing the MaxNet loop around a four-lane PU stage.
// Latency: a run of k PU evaluations raises done k*(PU_LAT+1) cycles after the accepted start edge.
// Backpressure: none; start is honoured only in IDLE and is silently dropped in every other state.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   start, in0..in3      run request and initial activations (sampled together in IDLE)
//   pu_out0..pu_out3     PU lane results, sampled in CHECK
//   x0..x3               registered activations driving the PU x inputs
//   busy, done           run in progress (inclusive of done cycle), one-cycle completion pulse
//   found, winner        unique survivor flag and its lane index (held until next start)
//   timeout, iter_cnt    run ended on MAX_ITER, PU evaluations used (held)
//
// Build option: define MAXNET_CLAMP_EN to treat negative PU lanes as dead
// (counted as zero and fed back as zero). Default build passes lanes through unmodified.
module maxnet_ctrl #(
  parameter int W        = 5,
  parameter int PU_LAT   = 1,
  parameter int MAX_ITER = 16,
  localparam int IW      = $clog2(MAX_ITER + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  in0,
  input  logic [W-1:0]  in1,
  input  logic [W-1:0]  in2,
  input  logic [W-1:0]  in3,
  input  logic [W-1:0]  pu_out0,
  input  logic [W-1:0]  pu_out1,
  input  logic [W-1:0]  pu_out2,
  input  logic [W-1:0]  pu_out3,
  output logic [W-1:0]  x0,
  output logic [W-1:0]  x1,
  output logic [W-1:0]  x2,
  output logic [W-1:0]  x3,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [1:0]    winner,
  output logic          timeout,
  output logic [IW-1:0] iter_cnt
);

  // Wait counter must hold PU_LAT; keep at least one bit so PU_LAT=0 still elaborates.
  localparam int CW = (PU_LAT < 1) ? 1 : $clog2(PU_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [3:0][W-1:0] lanes_t;

  state_t        state_q, state_d;
  lanes_t        x_q, x_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          found_q, found_d;
  logic [1:0]    winner_q, winner_d;
  logic          timeout_q, timeout_d;
  logic [IW-1:0] iter_q, iter_d;

  lanes_t        pu;
  lanes_t        v;
  logic [2:0]    n_alive;
  logic [1:0]    alive_idx;

  assign pu = {pu_out3, pu_out2, pu_out1, pu_out0};

  // Lane survival: v is both what gets counted and what gets fed back.
  // alive_idx ends on the highest live lane, which is the winner whenever n_alive==1.
  always_comb begin : lane_eval
    v         = pu;
    n_alive   = '0;
    alive_idx = '0;
`ifdef MAXNET_CLAMP_EN
    for (int i = 0; i < 4; i++) begin
      if (pu[i][W-1]) v[i] = '0;
    end
`endif
    for (int i = 0; i < 4; i++) begin
      if (v[i] != '0) begin
        n_alive   = n_alive + 3'd1;
        alive_idx = 2'(i);
      end
    end
  end

  always_comb begin : fsm_next
    state_d   = state_q;
    x_d       = x_q;
    wcnt_d    = wcnt_q;
    found_d   = found_q;
    winner_d  = winner_q;
    timeout_d = timeout_q;
    iter_d    = iter_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d       = {in3, in2, in1, in0};
          found_d   = 1'b0;
          winner_d  = 2'd0;
          timeout_d = 1'b0;
          iter_d    = '0;
          wcnt_d    = CW'(PU_LAT);
          // A zero-latency PU is already valid on the next edge, so skip WAIT entirely.
          state_d   = (PU_LAT == 0) ? CHECK : WAIT;
        end
      end

      WAIT: begin
        // Leave on the edge where the counter would reach zero, so the
        // CHECK edge lands exactly PU_LAT+1 edges after x was updated.
        if (wcnt_q > CW'(1)) begin
          wcnt_d = wcnt_q - CW'(1);
        end else begin
          wcnt_d  = '0;
          state_d = CHECK;
        end
      end

      CHECK: begin
        iter_d = iter_q + IW'(1);
        // Precedence: unique survivor, then extinction, then iteration limit.
        if (n_alive == 3'd1) begin
          found_d  = 1'b1;
          winner_d = alive_idx;
          state_d  = DONE;
        end else if (n_alive == 3'd0) begin
          found_d  = 1'b0;
          winner_d = 2'd0;
          state_d  = DONE;
        end else if (iter_q == IW'(MAX_ITER - 1)) begin
          timeout_d = 1'b1;
          found_d   = 1'b0;
          winner_d  = 2'd0;
          state_d   = DONE;
        end else begin
          x_d     = v;
          wcnt_d  = CW'(PU_LAT);
          state_d = (PU_LAT == 0) ? CHECK : WAIT;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin : fsm_regs
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      wcnt_q    <= '0;
      found_q   <= 1'b0;
      winner_q  <= 2'd0;
      timeout_q <= 1'b0;
      iter_q    <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      wcnt_q    <= wcnt_d;
      found_q   <= found_d;
      winner_q  <= winner_d;
      timeout_q <= timeout_d;
      iter_q    <= iter_d;
    end
  end

  assign x0       = x_q[0];
  assign x1       = x_q[1];
  assign x2       = x_q[2];
  assign x3       = x_q[3];
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign found    = found_q;
  assign winner   = winner_q;
  assign timeout  = timeout_q;
  assign iter_cnt = iter_q;

endmodule

// File: tb/tb_maxnet_ctrl.sv
`timescale 1ns/1ps
module tb_maxnet_ctrl;

  localparam int W    = 5;
  localparam int LAT  = 1;
  localparam int MAXI = 8;
  localparam int IW   = $clog2(MAXI + 1);
`ifdef MAXNET_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  typedef logic [3:0][W-1:0] vec_t;
  typedef struct { int e; int dc; bit found; int winner; bit tout; int iter; } res_t;
  typedef struct { int c; vec_t x; } xexp_t;

  logic          clk = 1'b0;
  logic          rst, start;
  vec_t          inv, puv;
  logic [W-1:0]  x0, x1, x2, x3;
  logic          busy, done, found, timeout;
  logic [1:0]    winner;
  logic [IW-1:0] iter_cnt;

  maxnet_ctrl #(.W(W), .PU_LAT(LAT), .MAX_ITER(MAXI)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in0(inv[0]), .in1(inv[1]), .in2(inv[2]), .in3(inv[3]),
    .pu_out0(puv[0]), .pu_out1(puv[1]), .pu_out2(puv[2]), .pu_out3(puv[3]),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .busy(busy), .done(done), .found(found), .winner(winner),
    .timeout(timeout), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Scoreboard state shared by stimulus (push) and monitor (pop).
  res_t  q[$];
  xexp_t xq[$];
  vec_t  script[$];
  int    rst_chk = -1;
  bit    mon_en = 1'b0;
  bit    fin_req = 1'b0;
  bit    fin_done = 1'b0;

  // Reference model outputs.
  int    mk, mwin;
  bit    mfound, mtout;
  vec_t  mxs[$];

  function automatic vec_t mk4(int a, int b, int c, int d);
    vec_t v;
    v[0] = W'(a); v[1] = W'(b); v[2] = W'(c); v[3] = W'(d);
    return v;
  endfunction

  function automatic vec_t rvec();
    vec_t v;
    for (int i = 0; i < 4; i++)
      v[i] = ($urandom_range(0, 2) == 0) ? '0 : W'($urandom_range(1, (1 << W) - 1));
    return v;
  endfunction

  // A lane is alive if nonzero; with clamping, a negative lane counts as zero.
  function automatic vec_t survivors(vec_t p);
    vec_t r = p;
    for (int i = 0; i < 4; i++)
      if (CLAMP && p[i][W-1]) r[i] = '0;
    return r;
  endfunction

  // MaxNet loop evaluated directly: iterate the scripted PU results until one
  // lane survives, none survive, or the evaluation budget is spent.
  function automatic void run_model();
    mxs.delete();
    mk = 0; mfound = 0; mwin = 0; mtout = 0;
    for (int k = 1; k <= MAXI; k++) begin
      vec_t v = survivors(script[k-1]);
      int n = 0;
      int last = 0;
      for (int i = 0; i < 4; i++) if (v[i] != '0) begin n++; last = i; end
      mk = k;
      if (n == 1) begin mfound = 1; mwin = last; return; end
      if (n == 0) return;
      if (k == MAXI) begin mtout = 1; return; end
      mxs.push_back(v);
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin @(posedge clk); #2; end
  endtask

  task automatic pad_script();
    while (script.size() < MAXI) script.push_back(rvec());
  endtask

  // One run: early=1 means start is raised during the previous run's done
  // cycle, where it must be ignored, so acceptance lands one edge later.
  // abort_at=j asserts rst during the WAIT preceding evaluation j.
  task automatic run(input vec_t in_v, input bit early, input int abort_at, input bit poke);
    res_t  r;
    xexp_t xe;
    int    e;
    run_model();
    e = cyc + (early ? 2 : 1);
    r.e = e; r.dc = e + mk * (LAT + 1);
    r.found = mfound; r.winner = mwin; r.tout = mtout; r.iter = mk;
    q.push_back(r);
    xe.c = e; xe.x = in_v; xq.push_back(xe);
    foreach (mxs[j]) begin
      xe.c = e + (j + 1) * (LAT + 1); xe.x = mxs[j]; xq.push_back(xe);
    end
    inv = in_v; puv = script[0]; start = 1'b1;
    wait_cyc(e);
    start = 1'b0;
    if (poke) begin
      start = 1'b1; inv = mk4(7, 7, 7, 7);
      wait_cyc(e + 1);
      start = 1'b0;
    end
    for (int j = 1; j <= mk; j++) begin
      wait_cyc(e + (j - 1) * (LAT + 1));
      puv = script[j-1];
      if (abort_at == j) begin
        rst = 1'b1;
        wait_cyc(cyc + 1);
        rst = 1'b0;
        q.delete(); xq.delete();
        xe.c = cyc; xe.x = '0; xq.push_back(xe);
        rst_chk = cyc;
        return;
      end
    end
    wait_cyc(e + mk * (LAT + 1));
  endtask

  // Monitor: checks every output each cycle against the expectation queues.
  vec_t  ex = '0;
  bit    ef = 0, et = 0;
  int    ew = 0, ei = 0;
  res_t  r_m;
  xexp_t xe_m;
  bit    eb, ed;

  always @(negedge clk) begin
    if (mon_en) begin
      if (cyc == rst_chk) begin ef = 0; ew = 0; et = 0; ei = 0; end
      while (xq.size() > 0 && xq[0].c <= cyc) begin
        xe_m = xq.pop_front();
        ex = xe_m.x;
      end
      chk("x", 32'({x3, x2, x1, x0}), 32'(ex));
      eb = (q.size() > 0) && (cyc >= q[0].e) && (cyc <= q[0].dc);
      ed = (q.size() > 0) && (cyc == q[0].dc);
      if (q.size() > 0 && cyc == q[0].e) begin ef = 0; ew = 0; et = 0; end
      chk("busy", 32'(busy), 32'(eb));
      chk("done", 32'(done), 32'(ed));
      if (ed) begin
        r_m = q.pop_front();
        ef = r_m.found; ew = r_m.winner; et = r_m.tout; ei = r_m.iter;
        chk("iter_cnt_at_done", 32'(iter_cnt), 32'(ei));
      end
      chk("found", 32'(found), 32'(ef));
      chk("winner", 32'(winner), 32'(ew));
      chk("timeout", 32'(timeout), 32'(et));
      if (!eb) chk("iter_cnt_held", 32'(iter_cnt), 32'(ei));
      if (fin_req && !fin_done) begin
        chk("pending_runs", 32'(q.size()), 32'd0);
        fin_done = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; inv = '0; puv = '0;
    repeat (3) @(posedge clk);
    #2; rst = 1'b0;
    mon_en = 1'b1;
    wait_cyc(cyc + 2);

    // Convergence: winner lane 1 after three evaluations.
    script.delete();
    script.push_back(mk4(3, 5, 1, 0)); script.push_back(mk4(1, 4, 0, 0));
    script.push_back(mk4(0, 3, 0, 0)); pad_script();
    run(mk4(4, 6, 2, 1), 1'b0, 0, 1'b0);
    wait_cyc(cyc + 3);

    // Same run with a start pulse during WAIT, then an immediate restart
    // requested in the done cycle (all lanes die on the first check).
    run(mk4(4, 6, 2, 1), 1'b0, 0, 1'b1);
    script.delete(); script.push_back(mk4(0, 0, 0, 0)); pad_script();
    run(mk4(2, 2, 2, 2), 1'b1, 0, 1'b0);
    wait_cyc(cyc + 3);

    // Timeout: two lanes stay alive for the whole budget.
    script.delete();
    repeat (MAXI) script.push_back(mk4(1, 1, 0, 0));
    run(mk4(3, 3, 0, 0), 1'b0, 0, 1'b0);
    wait_cyc(cyc + 3);

    // Reset during the second WAIT, then a clean run.
    script.delete();
    repeat (MAXI) script.push_back(mk4(2, 3, 0, 0));
    run(mk4(4, 4, 1, 0), 1'b0, 2, 1'b0);
    wait_cyc(cyc + 3);
    script.delete(); script.push_back(mk4(0, 5, 0, 0)); pad_script();
    run(mk4(0, 5, 0, 0), 1'b0, 0, 1'b0);
    wait_cyc(cyc + 3);

    // Negative lane: dead when clamped, alive and fed back otherwise.
    script.delete();
    script.push_back(mk4(31, 2, 0, 0)); script.push_back(mk4(0, 0, 0, 0)); pad_script();
    run(mk4(1, 2, 3, 4), 1'b0, 0, 1'b0);
    wait_cyc(cyc + 3);

    // Randomised runs, some restarted straight out of the done cycle.
    for (int t = 0; t < 40; t++) begin
      script.delete();
      repeat (MAXI) script.push_back(rvec());
      run(rvec(), (t % 4 == 1), 0, 1'b0);
      if ((t + 1) % 4 != 1) wait_cyc(cyc + 2);
    end

    wait_cyc(cyc + 4);
    fin_req = 1'b1;
    repeat (3) @(negedge clk);
    if (!fin_done) begin
      fails++;
      $display("FAIL final_check: monitor did not complete, got 0, expected 1");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
